cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception and interrupt controller for the pipelined MIPS core. It consumes the decoder's int_cause, cause_write, exit_kernel and write_c0 outputs. It owns the STATUS, CAUSE, EPC, COUNT and COMPARE registers, arbitrates synchronous exceptions against a parametrised set of external interrupt lines plus a timer, and sequences kernel entry and exit through a small FSM. It drives the kernel_mode signal back to the decoder and the flush/redirect signals to the hazard unit.

Parameters:
NUM_IRQ, 4, external interrupt lines (legal 1..6); timer occupies pending bit index NUM_IRQ
EXC_VECTOR, 32'h80000180, PC loaded on exception entry
SYNC_STAGES, 2, synchroniser flops per irq line (legal 2..3)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
stall_i  in  1  pipeline stall; freezes FSM and register writes except COUNT, irq sync and IP set
instr_valid_i  in  1  instruction in decode/exec is real (not a bubble)
pc_i  in  32  PC of that instruction
int_cause_i  in  3  decoder cause code (0 = none)
cause_write_i  in  1  decoder synchronous-exception flag
exit_kernel_i  in  1  ERET-type jump_reg
write_c0_i  in  1  mtc0
c0_addr_i  in  5  CP0 register select
c0_wdata_i  in  32  mtc0 data
irq_i  in  NUM_IRQ  async level interrupt lines
c0_rdata_o  out  32  mfc0 read data (combinational)
kernel_mode_o  out  1  1 = kernel mode
exc_taken_o  out  1  one-cycle flush + redirect pulse
exc_vector_o  out  32  constant EXC_VECTOR
epc_o  out  32  current EPC, used as ERET target

Behaviour:
- Registers and addresses (unmapped reads return 0):
  - STATUS (12): bit0 IE, bit1 KM, bits[8+NUM_IRQ:8] IM.
  - CAUSE (13): bits[4:2] EXC, bits[8+NUM_IRQ:8] IP, bit31 DF.
  - EPC (14).
  - COUNT (9).
  - COMPARE (11).
- Reset values: FSM=KERNEL; KM=1, IE=0, IM=0; CAUSE=0; EPC=0; COUNT=0; COMPARE=32'hFFFFFFFF; sync flops=0; exc_taken_o=0.
- irq_i path:
  - Passes through SYNC_STAGES flops.
  - A synchronised 1 sets IP[i]. IP is sticky.
  - Software clears IP only by mtc0 CAUSE, which loads IP from c0_wdata.
  - A hardware set in the same cycle wins over a software clear.
- Timer:
  - COUNT increments every cycle and wraps 32'hFFFFFFFF -> 0.
  - COUNT==COMPARE sets IP[NUM_IRQ].
  - mtc0 COMPARE clears IP[NUM_IRQ]. An equality match in the same cycle loses to that clear.
- FSM states: USER, ENTRY, KERNEL. Nothing changes while stall_i=1, except COUNT, irq sync and IP set.
- USER state:
  - Priority 1: if instr_valid_i & cause_write_i, latch EXC=int_cause_i and EPC=pc_i, set KM=1, IE=0; next state ENTRY.
  - Priority 2: else if instr_valid_i & IE & |(IP & IM), latch EXC=3'b100 (interrupt) and EPC=pc_i, set KM=1, IE=0; next state ENTRY. IP is left unchanged.
  - A synchronous exception and an interrupt in the same cycle: the synchronous one is taken and the interrupt stays pending.
  - write_c0_i is ignored (the decoder already flags it as privileged).
- ENTRY state:
  - exc_taken_o=1 for exactly this cycle; all decoder inputs are ignored.
  - Next state KERNEL unconditionally; stall_i does not extend ENTRY.
  - Latency: detection at cycle N, exc_taken_o at N+1, kernel_mode_o stable 1 from N+1.
- KERNEL state:
  - Interrupts are not taken.
  - A valid cause_write_i sets DF=1 and overwrites EXC; EPC is unchanged; no redirect.
  - A valid write_c0_i writes the selected register on the next edge. Writing STATUS.KM has no effect on the FSM; KM is FSM-owned.
  - A valid exit_kernel_i: next state USER, KM=0, IE=1. The pipeline redirects to epc_o via jump_reg.
  - exit_kernel_i with write_c0_i in the same cycle is impossible by decode; if it occurs, exit_kernel_i wins.
- kernel_mode_o = KM, registered.
- c0_rdata_o reflects register state before the same-cycle write (no bypass).
- reset_n low in any state, including mid-ENTRY: all registers return immediately to reset values and exc_taken_o drops asynchronously.

Test Plan:
- Reset: reset_n=0 then 1 -> kernel_mode_o=1, exc_taken_o=0, mfc0 12 reads 32'h00000002, mfc0 13 reads 0.
- Overflow in user mode: set STATUS via mtc0 12, eret to USER, then present cause_write_i=1, int_cause_i=3'b001, pc_i=32'h00400010 -> exc_taken_o one cycle later for exactly 1 cycle; EPC=32'h00400010; CAUSE[4:2]=3'b001; kernel_mode_o=1; IE=0.
- Interrupt latency and masking: IM[8]=1, IE=1, USER; raise irq_i[0] at cycle 0 -> IP[8]=1 at cycle 2, EXC=3'b100 latched, exc_taken_o at cycle 3. With IM[8]=0 -> IP set, no exc_taken_o.
- Simultaneous events: synchronous exception and pending enabled irq in same cycle -> EXC=cause code, IP still 1. After eret, interrupt taken on next valid instruction.
- Timer: COMPARE=COUNT+5 -> IP[8+NUM_IRQ]=1 after 5 cycles. mtc0 COMPARE -> bit clears. COUNT wraps 32'hFFFFFFFF -> 0.
- Reset mid-entry and kernel fault: assert reset_n=0 during ENTRY -> exc_taken_o falls immediately, state KERNEL after release. In KERNEL, cause_write_i=1 -> DF=1, EPC unchanged, no exc_taken_o.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt controller: STATUS, CAUSE, EPC, COUNT, COMPARE and entry/exit FSM
module cp0_exc_ctrl #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] EXC_VECTOR  = 32'h80000180,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic               instr_valid_i,
    input  logic [31:0]        pc_i,
    input  logic [2:0]         int_cause_i,
    input  logic               cause_write_i,
    input  logic               exit_kernel_i,
    input  logic               write_c0_i,
    input  logic [4:0]         c0_addr_i,
    input  logic [31:0]        c0_wdata_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [31:0]        c0_rdata_o,
    output logic               kernel_mode_o,
    output logic               exc_taken_o,
    output logic [31:0]        exc_vector_o,
    output logic [31:0]        epc_o
);
    // Pending/mask width: external lines plus the timer at index NUM_IRQ
    localparam int NP = NUM_IRQ + 1;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    typedef enum logic [1:0] {
        ST_USER   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_KERNEL = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              km, ie, df;
    logic [NP-1:0]     im, ip, ip_sw, hw_set, pending;
    logic [2:0]        exc, take_code;
    logic [31:0]       epc, count, compare;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

    logic take, leave, kern_op, kern_fault, c0_wr, irq_req;

    // Decoder-driven actions only count for real, unstalled instructions in kernel mode
    assign kern_op    = (state == ST_KERNEL) && !stall_i && instr_valid_i;
    assign kern_fault = kern_op && cause_write_i;
    assign leave      = kern_op && exit_kernel_i;
    assign c0_wr      = kern_op && write_c0_i && !exit_kernel_i;

    // Hardware set sources; a same-cycle COMPARE write suppresses the timer match
    assign hw_set  = {(count == compare) && !(c0_wr && c0_addr_i == A_COMPARE),
                      sync_q[SYNC_STAGES-1]};
    // Arbitration sees lines being set this cycle, so detection is not delayed by IP
    assign pending = ip | hw_set;
    assign irq_req = ie && |(pending & im);

    // Irq synchroniser chain, runs regardless of stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_KERNEL;
        else          state <= state_nx;
    end

    // Next state and exception-entry decision; synchronous exceptions beat interrupts
    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        take_code = 3'b000;
        case (state)
            ST_USER: begin
                if (!stall_i && instr_valid_i) begin
                    if (cause_write_i) begin
                        take      = 1'b1;
                        take_code = int_cause_i;
                    end else if (irq_req) begin
                        take      = 1'b1;
                        take_code = 3'b100;
                    end
                end
                if (take) state_nx = ST_ENTRY;
            end
            ST_ENTRY:  state_nx = ST_KERNEL;
            ST_KERNEL: if (leave) state_nx = ST_USER;
            default:   state_nx = ST_KERNEL;
        endcase
    end

    // STATUS, EXC/DF and EPC updates; KM only ever follows the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            km  <= 1'b1;
            ie  <= 1'b0;
            im  <= '0;
            exc <= 3'b000;
            df  <= 1'b0;
            epc <= '0;
        end else begin
            if (take) begin
                exc <= take_code;
                epc <= pc_i;
                km  <= 1'b1;
                ie  <= 1'b0;
            end else if (leave) begin
                km <= 1'b0;
                ie <= 1'b1;
            end else if (c0_wr && c0_addr_i == A_STATUS) begin
                ie <= c0_wdata_i[0];
                im <= c0_wdata_i[8 +: NP];
            end
            if (kern_fault) begin
                df  <= 1'b1;
                exc <= int_cause_i;
            end
            if (c0_wr && c0_addr_i == A_EPC) epc <= c0_wdata_i;
        end
    end

    // Software view of IP before hardware sets are merged in
    always_comb begin
        ip_sw = ip;
        if (c0_wr && c0_addr_i == A_CAUSE)        ip_sw = c0_wdata_i[8 +: NP];
        else if (c0_wr && c0_addr_i == A_COMPARE) ip_sw[NUM_IRQ] = 1'b0;
    end

    // Timer and sticky pending bits; hardware sets win over software clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            compare <= 32'hFFFFFFFF;
            ip      <= '0;
        end else begin
            count <= (c0_wr && c0_addr_i == A_COUNT) ? c0_wdata_i : count + 32'd1;
            if (c0_wr && c0_addr_i == A_COMPARE) compare <= c0_wdata_i;
            ip <= ip_sw | hw_set;
        end
    end

    // mfc0 read mux, pre-write register contents
    always_comb begin
        c0_rdata_o = '0;
        case (c0_addr_i)
            A_STATUS: begin
                c0_rdata_o[0]       = ie;
                c0_rdata_o[1]       = km;
                c0_rdata_o[8 +: NP] = im;
            end
            A_CAUSE: begin
                c0_rdata_o[4:2]     = exc;
                c0_rdata_o[8 +: NP] = ip;
                c0_rdata_o[31]      = df;
            end
            A_EPC:     c0_rdata_o = epc;
            A_COUNT:   c0_rdata_o = count;
            A_COMPARE: c0_rdata_o = compare;
            default:   c0_rdata_o = '0;
        endcase
    end

    assign kernel_mode_o = km;
    assign exc_taken_o   = (state == ST_ENTRY);
    assign exc_vector_o  = EXC_VECTOR;
    assign epc_o         = epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed plus randomized bench for cp0_exc_ctrl against a behavioural model
module tb_cp0_exc_ctrl;
    localparam int NI = 4;
    localparam int SS = 2;
    localparam int NP = NI + 1;
    localparam int M_USER = 0, M_ENTRY = 1, M_KERN = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall_i, instr_valid_i, cause_write_i, exit_kernel_i, write_c0_i;
    logic [31:0]   pc_i, c0_wdata_i;
    logic [2:0]    int_cause_i;
    logic [4:0]    c0_addr_i;
    logic [NI-1:0] irq_i;
    logic [31:0]   c0_rdata_o, exc_vector_o, epc_o;
    logic          kernel_mode_o, exc_taken_o;

    cp0_exc_ctrl #(.NUM_IRQ(NI), .EXC_VECTOR(32'h80000180), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .instr_valid_i(instr_valid_i),
        .pc_i(pc_i), .int_cause_i(int_cause_i), .cause_write_i(cause_write_i),
        .exit_kernel_i(exit_kernel_i), .write_c0_i(write_c0_i), .c0_addr_i(c0_addr_i),
        .c0_wdata_i(c0_wdata_i), .irq_i(irq_i), .c0_rdata_o(c0_rdata_o),
        .kernel_mode_o(kernel_mode_o), .exc_taken_o(exc_taken_o),
        .exc_vector_o(exc_vector_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int r;

    // Reference model state
    int            m_mode;
    logic          m_km, m_ie, m_df;
    logic [NP-1:0] m_im, m_ip;
    logic [2:0]    m_exc;
    logic [31:0]   m_epc, m_count, m_compare;
    logic [NI-1:0] m_sync[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_KERN; m_km = 1'b1; m_ie = 1'b0; m_df = 1'b0;
        m_im = '0; m_ip = '0; m_exc = 3'b000;
        m_epc = '0; m_count = '0; m_compare = 32'hFFFFFFFF;
        m_sync = {};
        for (int i = 0; i < SS; i++) m_sync.push_back('0);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return 32'(m_ie) | (32'(m_km) << 1) | (32'(m_im) << 8);
            5'd13:   return (32'(m_exc) << 2) | (32'(m_ip) << 8) | (32'(m_df) << 31);
            5'd14:   return m_epc;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the architectural rules, applied to the model
    task automatic model_step();
        logic [NP-1:0] hw, pend;
        logic act, wr;
        act = instr_valid_i && !stall_i;
        wr  = (m_mode == M_KERN) && act && write_c0_i && !exit_kernel_i;
        hw  = {m_count == m_compare, m_sync[0]};
        if (wr && c0_addr_i == 5'd11) hw[NI] = 1'b0;
        pend = m_ip | hw;
        if (wr && c0_addr_i == 5'd13)      m_ip = c0_wdata_i[8 +: NP];
        else if (wr && c0_addr_i == 5'd11) m_ip[NI] = 1'b0;
        m_ip = m_ip | hw;
        m_count = (wr && c0_addr_i == 5'd9) ? c0_wdata_i : m_count + 32'd1;
        void'(m_sync.pop_front());
        m_sync.push_back(irq_i);
        case (m_mode)
            M_ENTRY: m_mode = M_KERN;
            M_USER: begin
                if (act && (cause_write_i || (m_ie && ((pend & m_im) != 0)))) begin
                    m_exc  = cause_write_i ? int_cause_i : 3'b100;
                    m_epc  = pc_i;
                    m_km   = 1'b1;
                    m_ie   = 1'b0;
                    m_mode = M_ENTRY;
                end
            end
            default: begin
                if (act) begin
                    if (cause_write_i) begin m_df = 1'b1; m_exc = int_cause_i; end
                    if (exit_kernel_i) begin
                        m_mode = M_USER; m_km = 1'b0; m_ie = 1'b1;
                    end else if (wr) begin
                        case (c0_addr_i)
                            5'd12: begin m_ie = c0_wdata_i[0]; m_im = c0_wdata_i[8 +: NP]; end
                            5'd14: m_epc = c0_wdata_i;
                            5'd11: m_compare = c0_wdata_i;
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    endtask

    // Called at a negedge with inputs set: compare outputs, advance one edge
    task automatic tick();
        #1;
        check("kernel_mode", 32'(kernel_mode_o), 32'(m_km));
        check("exc_taken", 32'(exc_taken_o), 32'(m_mode == M_ENTRY));
        check("epc", epc_o, m_epc);
        check("rdata", c0_rdata_o, model_read(c0_addr_i));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        stall_i = 1'b0; instr_valid_i = 1'b0; cause_write_i = 1'b0;
        exit_kernel_i = 1'b0; write_c0_i = 1'b0; int_cause_i = 3'b000;
        c0_wdata_i = '0; pc_i = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag,
                      input logic [31:0] mask = 32'hFFFFFFFF);
        c0_addr_i = a;
        #1;
        check(tag, c0_rdata_o & mask, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        instr_valid_i = 1'b1; write_c0_i = 1'b1; c0_addr_i = a; c0_wdata_i = d;
        tick();
        idle();
    endtask

    task automatic eret();
        instr_valid_i = 1'b1; exit_kernel_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic instr(input logic [31:0] pc, input logic cw, input logic [2:0] cause);
        instr_valid_i = 1'b1; pc_i = pc; cause_write_i = cw; int_cause_i = cause;
        tick();
        idle();
    endtask

    initial begin
        idle();
        irq_i = '0;
        c0_addr_i = 5'd0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_km", 32'(kernel_mode_o), 32'd1);
        check("rst_taken", 32'(exc_taken_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(5'd12, 32'h00000002, "rst_status");
        rd(5'd13, 32'h00000000, "rst_cause");
        check("vector", exc_vector_o, 32'h80000180);
        tick();

        // Overflow in user mode
        mtc0(5'd12, 32'h0);
        eret();
        check("user_km", 32'(kernel_mode_o), 32'd0);
        instr(32'h00400010, 1'b1, 3'b001);
        check("ovf_taken", 32'(exc_taken_o), 32'd1);
        check("ovf_epc", epc_o, 32'h00400010);
        check("ovf_km", 32'(kernel_mode_o), 32'd1);
        tick();
        check("ovf_taken_once", 32'(exc_taken_o), 32'd0);
        rd(5'd13, 32'h00000004, "ovf_cause");
        rd(5'd12, 32'h00000002, "ovf_status_ie0");
        tick();

        // Interrupt latency with IM[8] enabled
        mtc0(5'd12, 32'h00000100);
        eret();
        irq_i = 4'b0001;
        instr(32'h00400020, 1'b0, 3'b000);
        instr(32'h00400024, 1'b0, 3'b000);
        check("irq_not_yet", 32'(exc_taken_o), 32'd0);
        instr(32'h00400028, 1'b0, 3'b000);
        check("irq_taken_c3", 32'(exc_taken_o), 32'd1);
        check("irq_epc", epc_o, 32'h00400028);
        rd(5'd13, 32'h00000110, "irq_cause");
        irq_i = '0;
        for (int i = 0; i < 4; i++) tick();
        mtc0(5'd13, 32'h0);
        rd(5'd13, 32'h00000010, "ip_sw_clear");

        // Masked interrupt: IP sets, nothing taken
        mtc0(5'd12, 32'h0);
        eret();
        irq_i = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            instr(32'h00400040 + 32'(i * 4), 1'b0, 3'b000);
            check("masked_no_take", 32'(exc_taken_o), 32'd0);
        end
        rd(5'd13, 32'h00000210, "masked_ip");

        // Synchronous exception beats a pending enabled interrupt
        instr(32'h00400100, 1'b1, 3'b011);
        tick();
        mtc0(5'd12, 32'h00000200);
        eret();
        instr(32'h00400200, 1'b1, 3'b011);
        check("sim_taken", 32'(exc_taken_o), 32'd1);
        check("sim_epc", epc_o, 32'h00400200);
        rd(5'd13, 32'h0000020C, "sim_cause");
        irq_i = '0;
        tick();
        eret();
        instr(32'h00400300, 1'b0, 3'b000);
        check("irq_after_eret", 32'(exc_taken_o), 32'd1);
        check("irq_after_epc", epc_o, 32'h00400300);
        rd(5'd13, 32'h00000210, "irq_after_cause");
        tick();

        // Timer match, COMPARE-write clear, COUNT wrap
        mtc0(5'd13, 32'h0);
        mtc0(5'd11, m_count + 32'd5);
        c0_addr_i = 5'd13;
        for (int i = 0; i < 4; i++) tick();
        rd(5'd13, 32'h0, "timer_pre", 32'h00001000);
        tick();
        rd(5'd13, 32'h00001000, "timer_set", 32'h00001000);
        mtc0(5'd11, 32'hFFFFFFFF);
        rd(5'd13, 32'h0, "timer_clr", 32'h00001000);
        mtc0(5'd9, 32'hFFFFFFFE);
        rd(5'd9, 32'hFFFFFFFE, "count_fe");
        tick();
        rd(5'd9, 32'hFFFFFFFF, "count_ff");
        tick();
        rd(5'd9, 32'h00000000, "count_wrap");
        tick();

        // Reset during ENTRY, then a kernel-mode fault
        eret();
        instr(32'h00400400, 1'b1, 3'b001);
        check("entry_before_rst", 32'(exc_taken_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_taken", 32'(exc_taken_o), 32'd0);
        check("rst_async_km", 32'(kernel_mode_o), 32'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        rd(5'd12, 32'h00000002, "rst_mid_status");
        tick();
        instr(32'h00000123, 1'b1, 3'b101);
        check("kfault_no_take", 32'(exc_taken_o), 32'd0);
        check("kfault_epc", epc_o, 32'h0);
        rd(5'd13, 32'h80000014, "kfault_cause");
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            stall_i       = ($urandom_range(0, 7) == 0);
            instr_valid_i = ($urandom_range(0, 3) != 0);
            pc_i          = $urandom & 32'hFFFFFFFC;
            int_cause_i   = 3'($urandom);
            r             = $urandom_range(0, 9);
            cause_write_i = (r == 0);
            exit_kernel_i = (r == 1);
            write_c0_i    = (r == 2 || r == 3);
            case ($urandom_range(0, 5))
                0: c0_addr_i = 5'd9;
                1: c0_addr_i = 5'd11;
                2: c0_addr_i = 5'd12;
                3: c0_addr_i = 5'd13;
                4: c0_addr_i = 5'd14;
                default: c0_addr_i = 5'($urandom);
            endcase
            c0_wdata_i = $urandom;
            if (c0_addr_i == 5'd11 && $urandom_range(0, 1) == 1)
                c0_wdata_i = m_count + 32'($urandom_range(2, 9));
            if ($urandom_range(0, 15) == 0) irq_i = irq_i ^ NI'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
